// File: rtl/hazard_pkg.sv
// Shared definitions for the LEGv8 pipeline hazard controller.
// Register-file addressing, FSM state encoding and bubble counter width.
package hazard_pkg;

    localparam int unsigned REGADDRSIZE = 5;
    localparam logic [REGADDRSIZE-1:0] XZR = 5'd31;

    // Bubble counter width; bounds LOADUSE_BUBBLES to 1..15
    localparam int unsigned HZ_CNTSIZE = 4;

    typedef enum logic {
        HZ_RUN       = 1'b0,
        HZ_LOADSTALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_satcounter.sv
// Saturating up-counter used for hazard statistics.
// Holds at all-ones; asynchronous active-high reset to zero.
module satcounter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step on inc unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard.sv
// Pipeline interlock controller for the 5-stage LEGv8 core: load-use bubbles,
// taken-branch flush and data-memory freeze. Outputs are combinational from
// state, bubble counter and inputs.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard
    import hazard_pkg::*;
#(
    parameter int unsigned LOADUSE_BUBBLES = 1,
    parameter int unsigned CNTW            = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REGADDRSIZE-1:0] ifid_ra,
    input  logic [REGADDRSIZE-1:0] ifid_rb,
    input  logic                   ifid_usea,
    input  logic                   ifid_useb,
    input  logic                   idex_memread,
    input  logic [REGADDRSIZE-1:0] idex_rd,
    input  logic                   branch_taken,
    input  logic                   mem_busy,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   freeze
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNTW-1:0]        stall_count,
    output logic [CNTW-1:0]        flush_count,
    output logic [CNTW-1:0]        freeze_count
`endif
);

    localparam logic [HZ_CNTSIZE-1:0] BUBBLE_INIT = HZ_CNTSIZE'(LOADUSE_BUBBLES - 1);
    localparam logic [HZ_CNTSIZE-1:0] CNT_ONE     = HZ_CNTSIZE'(1);

    if ((LOADUSE_BUBBLES < 1) || (LOADUSE_BUBBLES > 15) || (CNTW < 1)) begin : g_bad_param
        $error("hazard: LOADUSE_BUBBLES must be 1..15 and CNTW at least 1");
    end

    hz_state_e             state_q, state_d;
    logic [HZ_CNTSIZE-1:0] cnt_q, cnt_d;

    logic busy, taken, loaduse;

    // Inputs are masked during reset so outputs show RUN values immediately
    always_comb begin
        busy    = mem_busy && !rst;
        taken   = branch_taken && !rst;
        loaduse = !rst && idex_memread && (idex_rd != XZR) &&
                  ((ifid_usea && (idex_rd == ifid_ra)) ||
                   (ifid_useb && (idex_rd == ifid_rb)));
    end

    // Priority resolution: memory wait, branch flush, bubble in progress, new load-use
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        freeze      = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (busy) begin
            freeze     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = HZ_RUN;
            cnt_d       = '0;
        end else if (state_q == HZ_LOADSTALL) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            cnt_d      = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = HZ_RUN;
            end
        end else if (loaduse) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (LOADUSE_BUBBLES > 1) begin
                state_d = HZ_LOADSTALL;
                cnt_d   = BUBBLE_INIT;
            end
        end
    end

    // FSM state and remaining-bubble counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    // A load-use bubble flushes ID/EX without EX/MEM; a branch flushes both
    satcounter #(.W(CNTW)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (idex_flush && !exmem_flush),
        .count (stall_count)
    );

    satcounter #(.W(CNTW)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (exmem_flush),
        .count (flush_count)
    );

    satcounter #(.W(CNTW)) u_freeze_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze),
        .count (freeze_count)
    );
`endif

endmodule

// File: tb/tb_hazard.sv
// Bench for hazard: two instances (1 and 3 bubbles) share stimulus and are
// compared every cycle against a remaining-bubble reference model.
module tb_hazard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ifid_ra, ifid_rb, idex_rd;
    logic       ifid_usea, ifid_useb, idex_memread, branch_taken, mem_busy;

    logic [5:0] outv [2];
`ifdef HAZARD_STATS_EN
    logic [31:0] st1, fl1, fz1;
    logic [3:0]  st3, fl3, fz3;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    // reference model state, index 0 = 1-bubble DUT, index 1 = 3-bubble DUT
    int          rem   [2] = '{0, 0};
    int          nbub  [2] = '{1, 3};
    longint      scnt  [2] = '{0, 0};
    longint      fcnt  [2] = '{0, 0};
    longint      zcnt  [2] = '{0, 0};
    longint      cmax  [2] = '{64'hFFFF_FFFF, 64'd15};

    always #5 clk = ~clk;

    hazard #(.LOADUSE_BUBBLES(1), .CNTW(32)) u_b1 (
        .clk(clk), .rst(rst), .ifid_ra(ifid_ra), .ifid_rb(ifid_rb),
        .ifid_usea(ifid_usea), .ifid_useb(ifid_useb), .idex_memread(idex_memread),
        .idex_rd(idex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(outv[0][5]), .ifid_write(outv[0][4]), .ifid_flush(outv[0][3]),
        .idex_flush(outv[0][2]), .exmem_flush(outv[0][1]), .freeze(outv[0][0])
`ifdef HAZARD_STATS_EN
        , .stall_count(st1), .flush_count(fl1), .freeze_count(fz1)
`endif
    );

    hazard #(.LOADUSE_BUBBLES(3), .CNTW(4)) u_b3 (
        .clk(clk), .rst(rst), .ifid_ra(ifid_ra), .ifid_rb(ifid_rb),
        .ifid_usea(ifid_usea), .ifid_useb(ifid_useb), .idex_memread(idex_memread),
        .idex_rd(idex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(outv[1][5]), .ifid_write(outv[1][4]), .ifid_flush(outv[1][3]),
        .idex_flush(outv[1][2]), .exmem_flush(outv[1][1]), .freeze(outv[1][0])
`ifdef HAZARD_STATS_EN
        , .stall_count(st3), .flush_count(fl3), .freeze_count(fz3)
`endif
    );

    function automatic bit is_loaduse();
        return idex_memread && idex_rd != 5'd31 &&
               ((ifid_usea && idex_rd == ifid_ra) || (ifid_useb && idex_rd == ifid_rb));
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze}
    function automatic logic [5:0] expect_out(int d);
        if (rst)          return 6'b110000;
        if (mem_busy)     return 6'b000001;
        if (branch_taken) return 6'b111110;
        if (rem[d] > 0 || is_loaduse()) return 6'b000100;
        return 6'b110000;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat_inc(longint v, longint m);
        return (v < m) ? v + 1 : v;
    endfunction

    // One clock: compare at negedge, advance model at posedge
    task automatic cycle(input string tag);
        @(negedge clk);
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                rem[d] = 0; scnt[d] = 0; fcnt[d] = 0; zcnt[d] = 0;
            end
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s.out%0d", tag, d), longint'(outv[d]), longint'(expect_out(d)));
        end
`ifdef HAZARD_STATS_EN
        check({tag, ".stall1"},  longint'(st1), scnt[0]);
        check({tag, ".flush1"},  longint'(fl1), fcnt[0]);
        check({tag, ".freeze1"}, longint'(fz1), zcnt[0]);
        check({tag, ".stall3"},  longint'(st3), scnt[1]);
        check({tag, ".flush3"},  longint'(fl3), fcnt[1]);
        check({tag, ".freeze3"}, longint'(fz3), zcnt[1]);
`endif
        @(posedge clk);
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (mem_busy) begin
                    zcnt[d] = sat_inc(zcnt[d], cmax[d]);
                end else if (branch_taken) begin
                    fcnt[d] = sat_inc(fcnt[d], cmax[d]);
                    rem[d] = 0;
                end else if (rem[d] > 0) begin
                    scnt[d] = sat_inc(scnt[d], cmax[d]);
                    rem[d]--;
                end else if (is_loaduse()) begin
                    scnt[d] = sat_inc(scnt[d], cmax[d]);
                    rem[d] = nbub[d] - 1;
                end
            end
        end
        #1;
    endtask

    task automatic drive(input string tag, input logic mr, input logic [4:0] rd,
                         input logic [4:0] ra, input logic ua, input logic [4:0] rb,
                         input logic ub, input logic bt, input logic mb);
        idex_memread = mr; idex_rd = rd; ifid_ra = ra; ifid_usea = ua;
        ifid_rb = rb; ifid_useb = ub; branch_taken = bt; mem_busy = mb;
        cycle(tag);
    endtask

    task automatic idle(input string tag);
        drive(tag, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive("reset_busy", 1'b1, 5'd1, 5'd1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1);
        idle("reset");
        rst = 1'b0;
        idle("idle");

        // load X1, ID reads X1 via ra
        drive("lu_ra", 1'b1, 5'd1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle("lu_ra_after");

        // load X2, ID reads X2 via rb
        drive("lu_rb", 1'b1, 5'd2, 5'd5, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle("lu_rb_after");

        // XZR and unused-source cases never stall
        drive("xzr", 1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0);
        drive("nousea", 1'b1, 5'd3, 5'd3, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        drive("nouseb", 1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        drive("noload", 1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);

        // branch during the 2nd bubble of a 3-bubble stall
        drive("br_lu", 1'b1, 5'd2, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        drive("br_flush", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) idle("br_after");

        // mem_busy for 4 cycles while 2 bubbles remain
        drive("mb_lu", 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive("mb_hold", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle("mb_after");

        // branch together with mem_busy is deferred
        for (int i = 0; i < 2; i++) drive("brmb", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        drive("brmb_flush", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle("brmb_after");

        // reset pulsed mid-stall
        drive("rst_lu", 1'b1, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        drive("rst_mid", 1'b1, 5'd6, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        idle("rst_after");

        // long freeze saturates the 4-bit counters of the 3-bubble instance
        for (int i = 0; i < 18; i++) drive("sat", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle("sat_after");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] pool [4];
            pool = '{5'd1, 5'd2, 5'd3, 5'd31};
            rst = ($urandom_range(0, 59) == 0);
            drive("rand", 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
                  pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                  pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end
        rst = 1'b0;
        idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
